sprite_io_regs: RTL
===================

Name: sprite_io_regs

Overview:
- Memory-mapped responder for the sprite position registers; receives store/load traffic already steered by the I/O address decoder (X at word address 120, Y at 121).
- Holds CPU-written staging X/Y values and commits them to the active position only at the start of vertical blanking, so the VGA renderer never draws a half-updated position.
- Also provides load readback and a frame counter.
- Sits between the processor data bus and the VGA sprite renderer.

Parameters:
- SCREEN_W, 640, horizontal resolution in pixels
- SCREEN_H, 480, vertical resolution in pixels
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- INIT_X, 0, X position after reset (must be <= SCREEN_W-SPRITE_W)
- INIT_Y, 0, Y position after reset (must be <= SCREEN_H-SPRITE_H)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  processor data-memory write enable
- sprite_enbX  in  1  decoder select for X register
- sprite_enbY  in  1  decoder select for Y register
- wd  in  32  processor write data
- rd  out  32  readback data for the processor load mux
- vblank  in  1  vertical-blanking level from the VGA controller (clk domain)
- sprite_x  out  10  active X position to renderer
- sprite_y  out  10  active Y position to renderer
- update_pending  out  1  staging differs from active (write not yet committed)
- frame_count  out  8  count of vblank rising edges

Behaviour:
- Reset (async, rst=1):
  - staging_x = active_x = INIT_X; staging_y = active_y = INIT_Y
  - update_pending = 0; frame_count = 0
  - vblank_q = 1, which suppresses a spurious commit if vblank is high when reset is released
- Write:
  - we & sprite_enbX loads staging_x on the next edge; we & sprite_enbY loads staging_y.
  - If both selects are asserted, X has priority and Y is not written.
  - Any accepted write sets update_pending = 1.
- Clamping, applied on write:
  - wd is interpreted as signed 32-bit.
  - wd < 0 stores 0.
  - X: wd > SCREEN_W-SPRITE_W (608) stores 608. Y: wd > SCREEN_H-SPRITE_H (448) stores 448.
  - Otherwise store wd[9:0].
- Commit:
  - vblank_q registers vblank every cycle; vb_rise = vblank & ~vblank_q.
  - On a vb_rise cycle: active_x/active_y take staging_x/staging_y as they stood before the edge; update_pending clears; frame_count increments, wrapping 255 -> 0.
  - A commit occurs on vb_rise even when update_pending = 0; active is unchanged in value.
- Simultaneous write and vb_rise in the same cycle:
  - Active takes the old staging value.
  - The new write lands in staging.
  - update_pending ends at 1.
- Readback, combinational, 0 cycles:
  - rd = {22'b0, staging_x} when sprite_enbX.
  - Otherwise rd = {22'b0, staging_y} when sprite_enbY.
  - Otherwise rd = {update_pending, 23'b0, frame_count}.
  - The last case is harmless, because the processor mux ignores rd unless a sprite select is asserted.
- sprite_x/sprite_y are driven directly from the active registers and change only on commit or reset.
- Reset mid-frame discards pending staging writes; the outputs return to INIT values immediately (asynchronous).

Decomposition:
- Shared package io_pkg:
  - ADDR_SPRITE_X = 120, ADDR_SPRITE_Y = 121, MEM_TOP = 119
  - POS_W = 10
  - typedef pos_t = logic [POS_W-1:0]
- One sub-module, sprite_axis_reg, instantiated twice (X and Y).
  - Parameters: LIMIT, INIT.
  - Contents: clamp logic, staging register, active register and the write-strobe/commit inputs.
- The top level contains the vblank edge detector, pending flag, frame counter and the readback mux.

Test Plan:
1. Reset with vblank held high, release, hold 5 cycles -> sprite_x=0, sprite_y=0, frame_count=0, no commit (vblank_q=1).
2. Write X=100 (we=1, enbX=1), then Y=200 -> rd reads back 100/200 with selects, sprite_x/y still 0, update_pending=1; pulse vblank 0->1 -> next edge sprite_x=100, sprite_y=200, pending=0, frame_count=1.
3. Write X=700, Y=-5 -> staging 608 and 0; after vb_rise sprite_x=608, sprite_y=0; write Y=448 -> stored 448, Y=449 -> stored 448.
4. staging_x=50 committed, then write X=60 in the same cycle as vb_rise -> sprite_x=50, staging 60, pending=1; next vb_rise -> sprite_x=60.
5. 256 vblank rising edges -> frame_count wraps to 0; vblank held high for many cycles counts once.
6. Assert rst asynchronously mid-clock with pending X=300 -> outputs immediately INIT values, pending=0; the following vb_rise does not commit 300.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O map constants and types for the memory-mapped peripherals.
package io_pkg;

  localparam int MEM_TOP       = 119;
  localparam int ADDR_SPRITE_X = 120;
  localparam int ADDR_SPRITE_Y = 121;

  localparam int POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/sprite_axis_reg.sv
// One sprite axis: clamped CPU staging register plus the active register
// that the renderer sees, updated only on a commit strobe.
module sprite_axis_reg
  import io_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int INIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic        commit_i,
  input  logic [31:0] wd_i,
  output logic [9:0]  staging_o,
  output logic [9:0]  active_o
);

  pos_t staging_q, staging_d;
  pos_t active_q,  active_d;
  pos_t clamped;

  // Write data is a signed software coordinate; pin it to the visible range.
  always_comb begin
    clamped = wd_i[POS_W-1:0];
    if ($signed(wd_i) < 0)
      clamped = '0;
    else if ($signed(wd_i) > LIMIT)
      clamped = POS_W'(LIMIT);
  end

  always_comb begin
    staging_d = wr_en_i  ? clamped   : staging_q;
    active_d  = commit_i ? staging_q : active_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging_q <= POS_W'(INIT);
      active_q  <= POS_W'(INIT);
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
    end
  end

  assign staging_o = staging_q;
  assign active_o  = active_q;

endmodule

// File: rtl/sprite_io_regs.sv
// Sprite position registers: CPU writes staging values, which become active
// at the start of vertical blanking so the renderer never sees a torn update.
module sprite_io_regs
  import io_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        sprite_enbX,
  input  logic        sprite_enbY,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        vblank,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic        update_pending,
  output logic [7:0]  frame_count
);

  logic       vblank_q;
  logic       vb_rise;
  logic       wr_x, wr_y;
  logic       pending_q, pending_d;
  logic [7:0] frame_q, frame_d;
  pos_t       staging_x, staging_y;

  assign vb_rise = vblank & ~vblank_q;
  // X wins when both selects are asserted.
  assign wr_x = we & sprite_enbX;
  assign wr_y = we & sprite_enbY & ~sprite_enbX;

  sprite_axis_reg #(
    .LIMIT(SCREEN_W - SPRITE_W),
    .INIT (INIT_X)
  ) u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_x),
    .commit_i (vb_rise),
    .wd_i     (wd),
    .staging_o(staging_x),
    .active_o (sprite_x)
  );

  sprite_axis_reg #(
    .LIMIT(SCREEN_H - SPRITE_H),
    .INIT (INIT_Y)
  ) u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_y),
    .commit_i (vb_rise),
    .wd_i     (wd),
    .staging_o(staging_y),
    .active_o (sprite_y)
  );

  // A write coinciding with commit lands after it, so it stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wr_x || wr_y)
      pending_d = 1'b1;
    else if (vb_rise)
      pending_d = 1'b0;
    frame_d = vb_rise ? frame_q + 8'd1 : frame_q;
  end

  // vblank_q resets high so vblank already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q  <= 1'b1;
      pending_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      vblank_q  <= vblank;
      pending_q <= pending_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    rd = {pending_q, 23'b0, frame_q};
    if (sprite_enbX)
      rd = {22'b0, staging_x};
    else if (sprite_enbY)
      rd = {22'b0, staging_y};
  end

  assign update_pending = pending_q;
  assign frame_count    = frame_q;

endmodule
